// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding an 8N1 UART transmitter (8E1 when the
//               UART_TX_PARITY_EN macro is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int c_BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int c_BAUD_W     = (c_BIT_CYCLES > 1) ? $clog2(c_BIT_CYCLES) : 1;
    localparam int c_DEPTH      = 2 ** ADDR_W;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } t_state;

    logic [7:0]          r_mem [c_DEPTH];
    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W:0]     r_rd_ptr;
    logic                r_overflow;
    logic                w_push_ok;
    logic                w_pop;

    t_state              r_state;
    t_state              w_state_next;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shreg;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_bit_end;
    logic                w_done;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign full      = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = push && !full;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    w_bit_next  = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_baud_next  = '0;
                w_bit_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The line level is decided from the state being entered, so tx changes
    // on the same edge as the state register
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shreg[w_bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = ^r_shreg;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_tx       <= w_tx_next;
            if (w_pop) begin
                r_shreg <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    assign overflow = r_overflow;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo (short bit time).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BC       = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [31:0] T1_BITS = 32'h460;
`else
    localparam int NBITS = 10;
    localparam logic [31:0] T1_BITS = 32'h260;
`endif
    localparam int FRAME = NBITS * BC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ADDR_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: samples each bit at its centre, counted from the first low sample
    logic [7:0]       rx_q[$];
    int               start_q[$];
    bit               mon_active = 1'b0;
    int               mon_off = 0;
    int               mon_start = 0;
    logic [NBITS-1:0] mon_bits = '0;
    logic [NBITS-1:0] last_bits = '0;
    int               done_cnt = 0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (!rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_off    = 0;
                mon_start  = cyc;
            end
        end else begin
            mon_off++;
        end
        if (rst && mon_active && (mon_off % BC) == BC / 2) begin
            mon_bits[mon_off / BC] = tx;
            if (mon_off / BC == 0) check("start_bit", {31'd0, tx}, 32'd0);
            if (mon_off / BC == NBITS - 1) begin
                check("stop_bit", {31'd0, tx}, 32'd1);
                rx_q.push_back(mon_bits[8:1]);
                start_q.push_back(mon_start);
                last_bits  = mon_bits;
                mon_active = 1'b0;
            end
        end
    end

    function automatic logic [7:0] rxb(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic do_reset();
        push = 1'b0;
        rst  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            push      = 1'b1;
            push_data = first + 8'(i);
            @(posedge clk);
            #1;
        end
        push = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
        check(tag, rx_q.size(), n);
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 4 * BC && tx_busy !== 1'b1; i++) @(negedge clk);
        check(tag, {31'd0, tx_busy}, 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int off;
        int lows;
        logic busy_last;
        logic busy_after;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Single byte 0x30: latency, bit pattern, tx_done position
        do_reset();
        push      = 1'b1;
        push_data = 8'h30;
        @(posedge clk);
        #1;
        push = 1'b0;
        @(negedge clk);
        check("t1_empty_pre", {31'd0, empty}, 32'd0);
        check("t1_tx_pre", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("t1_tx_fall", {31'd0, tx}, 32'd0);
        check("t1_empty_post", {31'd0, empty}, 32'd1);
        check("t1_busy", {31'd0, tx_busy}, 32'd1);
        cnt = 0;
        off = -1;
        busy_last = 1'b0;
        busy_after = 1'b1;
        for (int o = 1; o <= FRAME + 1; o++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                cnt++;
                off = o;
            end
            if (o == FRAME - 1) busy_last = tx_busy;
            if (o == FRAME) busy_after = tx_busy;
        end
        check("t1_done_cnt", cnt, 1);
        check("t1_done_off", off, FRAME - 1);
        check("t1_busy_last", {31'd0, busy_last}, 32'd1);
        check("t1_busy_idle", {31'd0, busy_after}, 32'd0);
        check("t1_frames", rx_q.size(), 1);
        check("t1_bits", 32'(last_bits), T1_BITS);

        // Three back-to-back frames
        do_reset();
        d0 = done_cnt;
        push_seq(8'h30, 3);
        wait_frames("t2_frames", 3, 4 * FRAME);
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 3; i++) check("t2_byte", rxb(i), 32'h30 + i);
        if (start_q.size() == 3) begin
            check("t2_gap01", start_q[1] - start_q[0], FRAME + 1);
            check("t2_gap12", start_q[2] - start_q[1], FRAME + 1);
        end
        check("t2_dones", done_cnt - d0, 3);

        // Overflow: 17 pushes while first byte is on the line
        do_reset();
        push_seq(8'hEE, 1);
        wait_busy("t3_busy");
        push_seq(8'h00, 16);
        @(negedge clk);
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_ovf_pre", {31'd0, overflow}, 32'd0);
        push_seq(8'h10, 1);
        @(negedge clk);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        wait_frames("t3_frames", 17, 18 * (FRAME + 1));
        check("t3_byte0", rxb(0), 32'hEE);
        for (int i = 1; i < 17; i++) check("t3_byte", rxb(i), i - 1);
        repeat (2 * FRAME) @(negedge clk);
        check("t3_no_0x10", rx_q.size(), 17);
        check("t3_empty", {31'd0, empty}, 32'd1);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Asynchronous reset in the middle of frame 0x55
        do_reset();
        push_seq(8'h55, 1);
        push_seq(8'h01, 3);
        for (int i = 0; i < 4 * BC && tx !== 1'b0; i++) @(negedge clk);
        repeat (4 * BC + BC / 2) @(negedge clk);
        check("t4_pre_tx", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("t4_tx", {31'd0, tx}, 32'd1);
        check("t4_empty", {31'd0, empty}, 32'd1);
        check("t4_busy", {31'd0, tx_busy}, 32'd0);
        check("t4_done", {31'd0, tx_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t4_line_idle", lows, 0);
        check("t4_frames", rx_q.size(), 0);

        // Push while full coinciding with a pop from IDLE
        do_reset();
        push_seq(8'hEE, 1);
        wait_busy("t5_busy");
        push_seq(8'h40, 16);
        @(negedge clk);
        check("t5_full", {31'd0, full}, 32'd1);
        check("t5_ovf_pre", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 2 * FRAME && tx_done !== 1'b1; i++) @(negedge clk);
        check("t5_done_seen", {31'd0, tx_done}, 32'd1);
        @(posedge clk);
        #1;
        push      = 1'b1;
        push_data = 8'hAA;
        @(negedge clk);
        check("t5_idle_full", {31'd0, full}, 32'd1);
        check("t5_idle_busy", {31'd0, tx_busy}, 32'd0);
        @(posedge clk);
        #1;
        push = 1'b0;
        @(negedge clk);
        check("t5_ovf", {31'd0, overflow}, 32'd1);
        check("t5_not_full", {31'd0, full}, 32'd0);
        check("t5_busy2", {31'd0, tx_busy}, 32'd1);
        wait_frames("t5_frames", 17, 18 * (FRAME + 1));
        check("t5_byte0", rxb(0), 32'hEE);
        for (int i = 1; i < 17; i++) check("t5_byte", rxb(i), 32'h3F + i);
        repeat (2 * FRAME) @(negedge clk);
        check("t5_no_0xaa", rx_q.size(), 17);
        check("t5_empty", {31'd0, empty}, 32'd1);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x31 has three ones, 0x33 has four
        do_reset();
        push_seq(8'h31, 1);
        wait_frames("t6_frames_a", 1, 2 * FRAME);
        check("t6_par_31", {31'd0, last_bits[9]}, 32'd1);
        check("t6_stop_31", {31'd0, last_bits[10]}, 32'd1);
        check("t6_byte_31", rxb(0), 32'h31);
        push_seq(8'h33, 1);
        wait_frames("t6_frames_b", 2, 3 * FRAME);
        check("t6_par_33", {31'd0, last_bits[9]}, 32'd0);
        check("t6_byte_33", rxb(1), 32'h33);
        if (start_q.size() == 2) check("t6_len", start_q[1] - start_q[0] >= FRAME, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
